// File: rtl/instr_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_encoder_if : descriptor-in / IMEM-write-out bus of the encoder |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err;
  logic [1:0]        err_code;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, err, err_code, full, count
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, err, err_code, full, count
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_encoder : packs RV32I descriptors into words, writes IMEM     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module instr_encoder #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                DEPTH  = 64
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       restart,
  instr_encoder_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] KIND_LW   = 3'b000;
  localparam logic [2:0] KIND_SW   = 3'b001;
  localparam logic [2:0] KIND_R    = 3'b010;
  localparam logic [2:0] KIND_BEQ  = 3'b011;
  localparam logic [2:0] KIND_IALU = 3'b100;
  localparam logic [2:0] KIND_JAL  = 3'b101;
  localparam logic [2:0] KIND_LUI  = 3'b110;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_ALIGN   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_REJECT = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        code_q, code_d;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        fits_i, fits_b, fits_j, shamt_ok, u_ok, is_shift;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        accept;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;

  // Sign-extension checks: the bits above the field must all copy its MSB.
  assign fits_i   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_j   = (&imm[31:20]) | ~(|imm[31:20]);
  assign shamt_ok = ~(|imm[31:5]);
  assign u_ok     = ~(|imm[11:0]);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    enc_word = 32'h0;
    enc_code = ERR_NONE;
    case (bus.in_kind)
      KIND_LW: begin
        enc_word = {imm[11:0], rs1, f3, rd, OP_LOAD};
        if (!fits_i) enc_code = ERR_RANGE;
      end
      KIND_SW: begin
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
        if (!fits_i) enc_code = ERR_RANGE;
      end
      KIND_R: begin
        enc_word = {1'b0, bus.in_funct7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
      end
      KIND_BEQ: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
        if (imm[0])       enc_code = ERR_ALIGN;
        else if (!fits_b) enc_code = ERR_RANGE;
      end
      KIND_IALU: begin
        if (is_shift) begin
          enc_word = {1'b0, bus.in_funct7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_IALU};
          if (!shamt_ok) enc_code = ERR_RANGE;
        end else begin
          enc_word = {imm[11:0], rs1, f3, rd, OP_IALU};
          if (!fits_i) enc_code = ERR_RANGE;
        end
      end
      KIND_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        if (imm[0])       enc_code = ERR_ALIGN;
        else if (!fits_j) enc_code = ERR_RANGE;
      end
      KIND_LUI: begin
        enc_word = {imm[31:12], rd, OP_LUI};
        if (!u_ok) enc_code = ERR_RANGE;
      end
      default: enc_code = ERR_ILLEGAL;
    endcase
  end

  assign bus.in_ready   = (state_q == S_IDLE) && !reset && !restart;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.imem_we    = (state_q == S_WRITE) && !reset && !restart;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.err        = (state_q == S_REJECT) && !reset;
  assign bus.err_code   = bus.err ? code_q : ERR_NONE;
  assign bus.full       = (state_q == S_FULL);
  assign bus.count      = count_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    code_d  = code_q;
    if (restart) begin
      state_d = S_IDLE;
      addr_d  = BASE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (enc_code == ERR_NONE) begin
              wdata_d = enc_word;
              state_d = S_WRITE;
            end else begin
              code_d  = enc_code;
              state_d = S_REJECT;
            end
          end
        end
        S_WRITE: begin
          addr_d  = addr_q + ADDR_W'(4);
          count_d = count_q + CNT_W'(1);
          state_d = (count_q == CNT_W'(DEPTH - 1)) ? S_FULL : S_IDLE;
        end
        S_REJECT: state_d = S_IDLE;
        S_FULL:   state_d = S_FULL;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
    end
  end
endmodule
`default_nettype wire
